// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared widths, state encoding and constants for the register file
package reg_file_pkg;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int ZERO_REG = 0;
    typedef enum logic {CLEAR, RUN} state_t;
endpackage

// File: rtl/reg_file_bypass.sv
// reg_file_bypass: one read port mux (zero register, write-first bypass, array)
module reg_file_bypass
    import reg_file_pkg::*;
#(
    parameter int DATA_W = reg_file_pkg::DATA_W,
    parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
    input  logic              run,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rd,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] data
);
    always_comb begin
        data = (!run || rs == ADDR_W'(ZERO_REG)) ? '0 :
               (wr_en && rd == rs)               ? wr_data : mem_data;
    end
endmodule

// File: rtl/reg_file.sv
// reg_file: 2R1W register file with r0 hard-wired to zero and a post-reset clear sweep
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W = reg_file_pkg::DATA_W,
    parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] read_a,
    output logic [DATA_W-1:0] read_b,
    output logic              ready
);
    localparam int DEPTH = 2 ** ADDR_W;
    state_t            state, state_nx;
    logic [ADDR_W-1:0] cnt, cnt_nx, waddr;
    logic [DATA_W-1:0] wdata;
    logic              we, last;
    logic [DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end
    always_comb begin
        last     = cnt == ADDR_W'(DEPTH - 1);
        state_nx = (state == CLEAR && last) ? RUN : state;
        cnt_nx   = (state == CLEAR && !last) ? cnt + 1'b1 : cnt;
    end
    // The sweep owns the single write port while clearing; user writes are dropped.
    always_comb begin
        ready = state == RUN;
        we    = ready ? (wr_en && rd != ADDR_W'(ZERO_REG)) : 1'b1;
        waddr = ready ? rd : cnt;
        wdata = ready ? wr_data : '0;
    end
    always_ff @(posedge clk) begin
        if (!rst && we)
            mem[waddr] <= wdata;
    end
    reg_file_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_a (
        .run(ready), .rs(rs1), .rd(rd), .wr_en(wr_en), .wr_data(wr_data),
        .mem_data(mem[rs1]), .data(read_a)
    );
    reg_file_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_b (
        .run(ready), .rs(rs2), .rd(rd), .wr_en(wr_en), .wr_data(wr_data),
        .mem_data(mem[rs2]), .data(read_b)
    );
endmodule
